i2c_burst_responder: RTL and testbench

I2C_BURST_RESPONDER -- requirements
Module: i2c_burst_responder

---
 rtl/i2c_burst_responder.sv | 163 ++++++++++++++++
 tb/tb_i2c_burst_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_burst_responder.sv
// Write-only I2C target that receives bursts of configurable-width words and ACKs each one.
// State | meaning: IDLE bus free | ADDR address+R/W | ADDR_ACK address ACK | DATA word bits | DATA_ACK word ACK | IGNORE NACK until START/STOP
module i2c_burst_responder #(
    parameter logic [6:0] OWN_ADDR = 7'h2A
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic        write,
    input  logic [3:0]  addin,
    input  logic [7:0]  data,
    output logic [31:0] rxOut,
    output logic        rxValid,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ADDR     = 3'd1;
    localparam logic [2:0] ADDR_ACK = 3'd2;
    localparam logic [2:0] DATA     = 3'd3;
    localparam logic [2:0] DATA_ACK = 3'd4;
    localparam logic [2:0] IGNORE   = 3'd5;

    logic [2:0]  state;
    logic        scl_s1, scl_s2, scl_d;
    logic        sda_s1, sda_s2, sda_d;
    logic [7:0]  size_reg, burst_reg;
    logic [5:0]  size_eff, last_bit;
    logic [7:0]  burst_eff;
    logic [5:0]  bit_cnt;
    logic [7:0]  word_cnt;
    logic [31:0] shreg, shifted;
    logic        scl_rise, scl_fall, start_det, stop_det, bit_rise, partial;

    // scl_d/sda_d hold the previous synchronized value for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_s1 <= 1'b0;
            scl_s2 <= 1'b0;
            scl_d  <= 1'b0;
            sda_s1 <= 1'b0;
            sda_s2 <= 1'b0;
            sda_d  <= 1'b0;
        end else begin
            scl_s1 <= scl_in;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= sda_in;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    assign scl_rise  = scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 & scl_d;
    assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
    assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
    assign bit_rise  = scl_rise & ~start_det & ~stop_det;

    assign size_eff  = (size_reg == 8'd0 || size_reg > 8'd32) ? 6'd32 : size_reg[5:0];
    assign last_bit  = size_eff - 6'd1;
    assign burst_eff = (burst_reg == 8'd0) ? 8'd1 : burst_reg;
    assign shifted   = {shreg[30:0], sda_s2};
    assign partial   = (state == DATA) && (bit_cnt != 6'd0);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            size_reg  <= 8'd8;
            burst_reg <= 8'd1;
        end else if (write && !busy && !start_det) begin
            case (addin)
                4'd1:    size_reg  <= data;
                4'd2:    burst_reg <= data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            sda_oe   <= 1'b0;
            rxOut    <= 32'd0;
            rxValid  <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            bit_cnt  <= 6'd0;
            word_cnt <= 8'd0;
            shreg    <= 32'd0;
        end else begin
            rxValid <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
            if (stop_det) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                error  <= partial;
            end else if (start_det) begin
                state    <= ADDR;
                sda_oe   <= 1'b0;
                error    <= partial;
                bit_cnt  <= 6'd0;
                word_cnt <= 8'd0;
                shreg    <= 32'd0;
            end else begin
                case (state)
                    ADDR: if (bit_rise) begin
                        if (bit_cnt == 6'd7) begin
                            bit_cnt <= 6'd0;
                            shreg   <= 32'd0;
                            state   <= (shifted[7:1] == OWN_ADDR && !shifted[0]) ? ADDR_ACK : IGNORE;
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                            shreg   <= shifted;
                        end
                    end
                    ADDR_ACK: if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                        end else begin
                            sda_oe <= 1'b0;
                            state  <= DATA;
                        end
                    end
                    // shreg is cleared between words, so the capture is right-justified
                    DATA: if (bit_rise) begin
                        if (bit_cnt == last_bit) begin
                            rxOut   <= shifted;
                            rxValid <= 1'b1;
                            bit_cnt <= 6'd0;
                            shreg   <= 32'd0;
                            state   <= DATA_ACK;
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                            shreg   <= shifted;
                        end
                    end
                    DATA_ACK: if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                        end else begin
                            sda_oe   <= 1'b0;
                            word_cnt <= word_cnt + 8'd1;
                            if (({1'b0, word_cnt} + 9'd1) < {1'b0, burst_eff}) begin
                                state <= DATA;
                            end else begin
                                done  <= 1'b1;
                                state <= IGNORE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_burst_responder.sv
// Directed bench for i2c_burst_responder: a bit-banged I2C master drives the bus while a
// forked monitor checks every rxValid against a queue of expected words.
module tb_i2c_burst_responder;

    localparam int Q = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        scl_m, sda_m, sda_bus;
    logic        sda_oe;
    logic        write;
    logic [3:0]  addin;
    logic [7:0]  data;
    logic [31:0] rxOut;
    logic        rxValid, busy, done, error;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    logic [31:0] exp_q[$];

    assign sda_bus = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_burst_responder #(.OWN_ADDR(7'h2A)) dut (
        .clk     (clk),
        .reset   (reset),
        .scl_in  (scl_m),
        .sda_in  (sda_bus),
        .sda_oe  (sda_oe),
        .write   (write),
        .addin   (addin),
        .data    (data),
        .rxOut   (rxOut),
        .rxValid (rxValid),
        .busy    (busy),
        .done    (done),
        .error   (error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (error) err_cnt++;
            if (rxValid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_rxValid: got rxOut 0x%0h, required no rxValid", rxOut);
                end else begin
                    check("rxOut", rxOut, exp_q.pop_front());
                end
            end
        end
    endtask

    task automatic cfg(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        write = 1'b1;
        addin = a;
        data  = d;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic bus_start();
        if (scl_m == 1'b0) begin
            sda_m = 1'b1;
            wait_clks(Q);
            scl_m = 1'b1;
            wait_clks(Q);
        end
        sda_m = 1'b0;
        wait_clks(2 * Q);
        scl_m = 1'b0;
        wait_clks(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0;
        wait_clks(Q);
        scl_m = 1'b1;
        wait_clks(Q);
        sda_m = 1'b1;
        wait_clks(2 * Q);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;
        wait_clks(Q);
        scl_m = 1'b1;
        wait_clks(2 * Q);
        scl_m = 1'b0;
        wait_clks(Q);
    endtask

    task automatic send_bits(input logic [31:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(val[i]);
    endtask

    task automatic ack_slot(input logic exp, input string name);
        sda_m = 1'b1;
        wait_clks(Q);
        scl_m = 1'b1;
        wait_clks(Q);
        check(name, {31'd0, sda_oe}, {31'd0, exp});
        wait_clks(Q);
        scl_m = 1'b0;
        wait_clks(Q);
    endtask

    initial begin
        reset = 1'b0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        write = 1'b0;
        addin = 4'd0;
        data  = 8'd0;
        fork
            monitor();
        join_none
        wait_clks(4);
        check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("rst_outputs", {rxOut, rxValid, busy, done, error} == 36'd0 ? 32'd1 : 32'd0, 32'd1);
        reset = 1'b1;
        wait_clks(4);

        // two-byte burst
        cfg(4'd1, 8'd8);
        cfg(4'd2, 8'd2);
        exp_q.push_back(32'h5C);
        exp_q.push_back(32'hA3);
        bus_start();
        send_bits(32'h54, 8);
        ack_slot(1'b1, "t1_addr_ack");
        check("t1_busy", {31'd0, busy}, 32'd1);
        send_bits(32'h5C, 8);
        ack_slot(1'b1, "t1_byte0_ack");
        send_bits(32'hA3, 8);
        ack_slot(1'b1, "t1_byte1_ack");
        bus_stop();
        check("t1_done_cnt", done_cnt, 1);
        check("t1_idle", {31'd0, busy}, 32'd0);

        // foreign address is NACKed and ignored until STOP
        bus_start();
        send_bits(32'h56, 8);
        ack_slot(1'b0, "t2_addr_nack");
        check("t2_busy", {31'd0, busy}, 32'd1);
        send_bits(32'h11, 8);
        ack_slot(1'b0, "t2_byte_nack");
        check("t2_busy_late", {31'd0, busy}, 32'd1);
        bus_stop();
        check("t2_idle", {31'd0, busy}, 32'd0);

        // 12-bit single-word burst, second word NACKed
        cfg(4'd1, 8'd12);
        cfg(4'd2, 8'd1);
        exp_q.push_back(32'h0000_0ABC);
        bus_start();
        send_bits(32'h54, 8);
        ack_slot(1'b1, "t3_addr_ack");
        send_bits(32'hABC, 12);
        ack_slot(1'b1, "t3_word_ack");
        check("t3_done_cnt", done_cnt, 2);
        send_bits(32'h123, 12);
        ack_slot(1'b0, "t3_second_nack");
        bus_stop();

        // STOP after 5 data bits aborts the word
        cfg(4'd1, 8'd8);
        bus_start();
        send_bits(32'h54, 8);
        ack_slot(1'b1, "t4_addr_ack");
        send_bits(32'h15, 5);
        bus_stop();
        check("t4_err_cnt", err_cnt, 1);
        check("t4_idle", {31'd0, busy}, 32'd0);
        check("t4_sda_oe", {31'd0, sda_oe}, 32'd0);

        // size write while busy is dropped; size=0 while idle selects 32-bit words
        exp_q.push_back(32'h3C);
        bus_start();
        send_bits(32'h54, 8);
        ack_slot(1'b1, "t5_addr_ack");
        cfg(4'd1, 8'd16);
        send_bits(32'h3C, 8);
        ack_slot(1'b1, "t5_byte_ack");
        bus_stop();
        check("t5_done_cnt_a", done_cnt, 3);
        cfg(4'd3, 8'd7);
        cfg(4'd1, 8'd0);
        exp_q.push_back(32'hDEAD_BEEF);
        bus_start();
        send_bits(32'h54, 8);
        ack_slot(1'b1, "t5_addr_ack2");
        send_bits(32'hDEAD_BEEF, 32);
        ack_slot(1'b1, "t5_word_ack");
        bus_stop();
        check("t5_done_cnt_b", done_cnt, 4);

        // reset during the address ACK slot
        bus_start();
        send_bits(32'h54, 8);
        sda_m = 1'b1;
        wait_clks(Q);
        scl_m = 1'b1;
        wait_clks(Q);
        check("t6_ack_before_rst", {31'd0, sda_oe}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("t6_rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("t6_rst_rxOut", rxOut, 32'd0);
        check("t6_rst_flags", {28'd0, rxValid, busy, done, error}, 32'd0);
        wait_clks(Q);
        scl_m = 1'b0;
        wait_clks(Q);
        reset = 1'b1;
        wait_clks(Q);
        send_bits(32'h54, 8);
        ack_slot(1'b0, "t6_no_start_nack");
        bus_stop();
        exp_q.push_back(32'h77);
        bus_start();
        send_bits(32'h54, 8);
        ack_slot(1'b1, "t6_addr_ack");
        send_bits(32'h77, 8);
        ack_slot(1'b1, "t6_byte_ack");
        bus_stop();
        check("t6_done_cnt", done_cnt, 5);
        check("final_err_cnt", err_cnt, 1);

        wait_clks(10);
        check("pending_rx", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
